// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: sequencer for the serial-in/serial-out shift datapath.
// Takes a parallel word over valid/ready and shifts it out MSB-first on
// sd_out with a matching shift_en strobe, a frame window and a done pulse.
// Optional build macro: SISO_SHIFT_CTRL_PARITY_EN appends an even-parity bit
// after the data bits (one extra bit period per word).
module siso_shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             abort,
   output logic             sd_out,
   output logic             shift_en,
   output logic             frame,
   output logic             done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
   localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [3:0] GAP_LAST = 4'(GAP_LAST_I);

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_DONE, ST_GAP} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_DONE, ST_GAP} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    bit_cnt;
   logic [3:0]       gap_cnt;
   logic             in_word;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   logic             parity;
   assign in_word = (state == ST_SHIFT) || (state == ST_PAR);
`else
   assign in_word = (state == ST_SHIFT);
`endif

   // Sequencer: state, datapath registers and registered outputs move together,
   // so each output register already holds the value for the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         sreg     <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         sd_out   <= 1'b0;
         shift_en <= 1'b0;
         frame    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         in_ready <= 1'b1;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (abort && in_word) begin
            // Cancel the word in flight: straight back to idle, no done, no gap.
            state    <= ST_IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            sd_out   <= 1'b0;
            shift_en <= 1'b0;
            frame    <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (in_valid) begin
                     state    <= ST_SHIFT;
                     sreg     <= in_data;
                     bit_cnt  <= '0;
                     sd_out   <= in_data[WIDTH-1];
                     shift_en <= 1'b1;
                     frame    <= 1'b1;
                     busy     <= 1'b1;
                     in_ready <= 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                     parity   <= ^in_data;
`endif
                  end
               end
               ST_SHIFT: begin
                  sreg    <= sreg << 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                     state    <= ST_PAR;
                     sd_out   <= parity;
`else
                     state    <= ST_DONE;
                     sd_out   <= 1'b0;
                     shift_en <= 1'b0;
                     frame    <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else begin
                     // Next MSB after the shift is the current second-highest bit.
                     sd_out <= sreg[WIDTH-2];
                  end
               end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
               ST_PAR: begin
                  state    <= ST_DONE;
                  sd_out   <= 1'b0;
                  shift_en <= 1'b0;
                  frame    <= 1'b0;
                  done     <= 1'b1;
               end
`endif
               ST_DONE: begin
                  if (GAP > 0) begin
                     state   <= ST_GAP;
                     gap_cnt <= '0;
                  end else begin
                     state    <= ST_IDLE;
                     busy     <= 1'b0;
                     in_ready <= 1'b1;
                  end
               end
               ST_GAP: begin
                  gap_cnt <= gap_cnt + 4'd1;
                  if (gap_cnt == GAP_LAST) begin
                     state    <= ST_IDLE;
                     busy     <= 1'b0;
                     in_ready <= 1'b1;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  sd_out   <= 1'b0;
                  shift_en <= 1'b0;
                  frame    <= 1'b0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb_siso_shift_ctrl: directed bench for siso_shift_ctrl, one DUT with GAP=0
// and one with GAP=2, both WIDTH=8.
module tb_siso_shift_ctrl;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic v0 = 1'b0, a0 = 1'b0, v2 = 1'b0, a2 = 1'b0;
   logic [7:0] d0 = 8'h00, d2 = 8'h00;
   logic rdy0, sd0, se0, fr0, dn0, bz0;
   logic rdy2, sd2, se2, fr2, dn2, bz2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   siso_shift_ctrl #(.WIDTH(8), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
      .abort(a0), .sd_out(sd0), .shift_en(se0), .frame(fr0), .done(dn0), .busy(bz0)
   );

   siso_shift_ctrl #(.WIDTH(8), .GAP(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
      .abort(a2), .sd_out(sd2), .shift_en(se2), .frame(fr2), .done(dn2), .busy(bz2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s value=%0h", tag, got);
      end
   endtask

   // Send one word into dut0 and observe it until in_ready returns.
   // abort_at: 0 = abort held with in_valid on the transfer edge, c>0 = abort
   // raised after sampling bit cycle c, -1 = no abort.
   task automatic run_word(input string tag, input logic [7:0] data, input int abort_at,
                           input logic [31:0] exp_bits, input int exp_nb,
                           input int exp_done_cyc, input int exp_done_cnt, input int exp_rdy);
      logic [31:0] bits;
      int nb, done_cyc, done_cnt, rdy_cyc, fmis;
      @(negedge clk);
      d0 = data; v0 = 1'b1; a0 = (abort_at == 0);
      @(posedge clk);
      #1 v0 = 1'b0; a0 = 1'b0;
      bits = 0; nb = 0; done_cyc = 0; done_cnt = 0; rdy_cyc = -1; fmis = 0;
      for (int c = 1; c <= 40 && rdy_cyc < 0; c++) begin
         @(negedge clk);
         if (se0) begin bits = (bits << 1) | {31'd0, sd0}; nb++; end
         if (fr0 != se0) fmis++;
         if (dn0) begin done_cnt++; done_cyc = c; end
         if (rdy0) rdy_cyc = c;
         a0 = (c == abort_at);
      end
      a0 = 1'b0;
      check({tag, ".bits"}, bits, exp_bits);
      check({tag, ".nbits"}, nb, exp_nb);
      check({tag, ".frame_match"}, fmis, 0);
      check({tag, ".done_cyc"}, done_cyc, exp_done_cyc);
      check({tag, ".done_cnt"}, done_cnt, exp_done_cnt);
      check({tag, ".ready_cyc"}, rdy_cyc, exp_rdy);
   endtask

   initial begin
      logic [31:0] bits2;
      logic [31:0] exp_b2b;
      int t1, t2, n_se, fm2;

      // Reset state
      #12;
      check("rst.in_ready0", rdy0, 1);
      check("rst.busy0", bz0, 0);
      check("rst.shift_en0", se0, 0);
      check("rst.done0", dn0, 0);
      check("rst.in_ready2", rdy2, 1);
      @(negedge clk);
      rst = 1'b0;

      // Reset asserted mid-SHIFT between edges
      @(negedge clk);
      d0 = 8'h5A; v0 = 1'b1;
      @(posedge clk);
      #1 v0 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 check("midrst.frame_before", fr0, 1);
      rst = 1'b1;
      #1;
      check("midrst.shift_en", se0, 0);
      check("midrst.frame", fr0, 0);
      check("midrst.busy", bz0, 0);
      check("midrst.in_ready", rdy0, 1);
      check("midrst.done", dn0, 0);
      @(negedge clk);
      rst = 1'b0;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
      run_word("post_rst_a5", 8'hA5, -1, {8'hA5, 1'b0}, 9, 10, 1, 11);
      run_word("basic_a5", 8'hA5, -1, {8'hA5, 1'b0}, 9, 10, 1, 11);
      run_word("par_07", 8'h07, -1, {8'h07, 1'b1}, 9, 10, 1, 11);
      run_word("par_03", 8'h03, -1, {8'h03, 1'b0}, 9, 10, 1, 11);
      run_word("abort_valid_81", 8'h81, 0, {8'h81, 1'b0}, 9, 10, 1, 11);
`else
      run_word("post_rst_a5", 8'hA5, -1, 32'hA5, 8, 9, 1, 10);
      run_word("basic_a5", 8'hA5, -1, 32'hA5, 8, 9, 1, 10);
      run_word("abort_valid_81", 8'h81, 0, 32'h81, 8, 9, 1, 10);
`endif
      // Abort on the 4th bit cycle: only 1,1,0,0 strobed, ready next cycle
      run_word("abort_c3", 8'hC3, 4, 32'hC, 4, 0, 0, 5);

      // Back-to-back on the GAP=2 instance with in_valid held high
      @(negedge clk);
      d2 = 8'hFF; v2 = 1'b1;
      t1 = -1; t2 = -1; n_se = 0; fm2 = 0; bits2 = 0;
      for (int n = 0; n < 32; n++) begin
         if (n > 0) @(negedge clk);
         if (se2) begin bits2 = (bits2 << 1) | {31'd0, sd2}; n_se++; end
         if (fr2 != se2) fm2++;
         if (t1 >= 0 && n == t1 + 4) d2 = 8'hAA;
         if (t1 >= 0 && n == t1 + 8) d2 = 8'h00;
         if (rdy2 && v2) begin
            if (t1 < 0) t1 = n;
            else begin t2 = n; end
         end
         if (t2 >= 0 && n == t2 + 1) v2 = 1'b0;
      end
      v2 = 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
      exp_b2b = {14'd0, 8'hFF, 1'b0, 8'h00, 1'b0};
`else
      exp_b2b = {16'd0, 8'hFF, 8'h00};
`endif
      check("b2b.spacing", t2 - t1, NB + 4);
      check("b2b.shift_cnt", n_se, 2 * NB);
      check("b2b.bits", bits2, exp_b2b);
      check("b2b.frame_match", fm2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
